samab_main_control: RTL
=======================

Name: samab_main_control

Overview:
- Multi-cycle main control FSM for the SAMAB CPU datapath.
- Decodes the instruction opcode and sequences fetch, decode, execute, memory and writeback.
- Drives the 3-bit `ops` field consumed by the ALU control decoder; the instruction func field goes straight from IR to that decoder.
- Handles a memory ready handshake and counts retired instructions.

Parameters:
- OPW, 4, opcode width (instr[15:12]).
- CNTW, 16, width of retired-instruction counter.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- opcode  input  OPW  IR[15:12], valid from DECODE onward
- zero  input  1  ALU zero flag
- mem_ready  input  1  memory completes current access this cycle
- ops  output  3  ALU op class: 000 add, 011 subtract, 100 R-type (use func)
- ir_write  output  1  load IR
- pc_write  output  1  unconditional PC load
- pc_write_cond  output  1  PC load if zero
- pc_src  output  2  00 ALU result, 01 ALUOut (branch target), 10 jump target
- iord  output  1  0 = PC addresses memory, 1 = ALUOut
- mem_read  output  1  memory read request
- mem_write  output  1  memory write request
- alu_src_a  output  1  0 = PC, 1 = reg A
- alu_src_b  output  2  00 reg B, 01 constant 1, 10 sign-extended imm
- reg_dst  output  1  1 = rd field, 0 = rt field
- mem_to_reg  output  1  1 = MDR, 0 = ALUOut
- reg_write  output  1  register file write
- halted  output  1  FSM in HALT
- illegal  output  1  sticky; set when halt caused by an undefined opcode
- retired  output  CNTW  retired-instruction count

Behaviour:
- Clock and reset:
  - One clock; reset is synchronous and active-high, sampled on the rising edge of clk.
  - rst=1 sets state to FETCH and clears `retired` and `illegal`.
  - While rst=1, every enable output is forced 0, `ops`=000, and all selects are 0.
- Outputs are Moore decodes of state. The exceptions, gated by mem_ready, are `ir_write`/`pc_write` in FETCH and the MEM_RD/MEM_WR exits.
- Opcodes:
  - 0000 R-type
  - 0001 ADDI
  - 0010 LW
  - 0011 SW
  - 0100 BEQ
  - 0101 J
  - 1111 HALT
  - all others are illegal.
- States and transitions:
  - FETCH: mem_read=1, iord=0, alu_src_a=0, alu_src_b=01, ops=000, pc_src=00.
    - If mem_ready: ir_write=1, pc_write=1, go to DECODE.
    - Else hold FETCH with ir_write=pc_write=0.
  - DECODE: alu_src_a=0, alu_src_b=10, ops=000 (branch target into ALUOut). Next state by opcode:
    - R-type -> EXEC_R
    - ADDI, LW, SW -> ADDR
    - BEQ -> BRANCH
    - J -> JUMP
    - HALT or illegal -> HALT; `illegal` is set if the opcode is undefined.
  - EXEC_R: alu_src_a=1, alu_src_b=00, ops=100 -> WB_R.
  - WB_R: reg_write=1, reg_dst=1, mem_to_reg=0 -> FETCH; retire.
  - ADDR: alu_src_a=1, alu_src_b=10, ops=000. Next state:
    - LW -> MEM_RD
    - SW -> MEM_WR
    - ADDI -> WB_I
  - WB_I: reg_write=1, reg_dst=0, mem_to_reg=0 -> FETCH; retire.
  - MEM_RD: mem_read=1, iord=1. Hold until mem_ready, then -> WB_MEM.
  - WB_MEM: reg_write=1, reg_dst=0, mem_to_reg=1 -> FETCH; retire.
  - MEM_WR: mem_write=1, iord=1. Hold until mem_ready, then -> FETCH; retire.
  - BRANCH: alu_src_a=1, alu_src_b=00, ops=011, pc_write_cond=1, pc_src=01 -> FETCH; retire.
  - JUMP: pc_write=1, pc_src=10 -> FETCH; retire.
  - HALT: all enables 0, halted=1. Only rst exits.
- Instruction count and cycle counts:
  - `retired` increments by 1 on each transition into FETCH from a terminal state.
  - `retired` wraps from 2^CNTW-1 to 0.
  - Cycle counts with no wait states: R=4, ADDI=4, LW=5, SW=4, BEQ=3, J=3.
  - Each cycle mem_ready=0 in FETCH, MEM_RD or MEM_WR adds one cycle.
- Boundary conditions:
  - mem_ready is ignored in states without a memory request.
  - mem_read and mem_write are never both 1.
  - rst asserted mid-instruction (including during a stalled MEM_WR): the in-flight access is abandoned, and FETCH occurs on the first cycle after rst falls.
  - opcode is only sampled in DECODE and ADDR; changes elsewhere have no effect.

Test Plan:
- Reset, then R-type opcode 0000, mem_ready=1 always -> states FETCH, DECODE, EXEC_R, WB_R; ops=100 in EXEC_R; reg_write=1, reg_dst=1 only in WB_R; retired=1 after 4 cycles.
- LW with mem_ready low 3 cycles in MEM_RD -> mem_read=1, iord=1 held 4 cycles; WB_MEM has mem_to_reg=1; total 8 cycles; retired increments once.
- BEQ with zero=1, then BEQ with zero=0 -> both show ops=011, pc_write_cond=1, pc_src=01 in BRANCH; each takes 3 cycles; retired=2.
- FETCH stall: mem_ready=0 for 5 cycles -> ir_write=pc_write=0 throughout, state stays FETCH; on mem_ready=1, ir_write=pc_write=1 in that cycle only.
- Opcode 0111 -> HALT after DECODE; halted=1, illegal=1, all enables 0 for 20 cycles; rst -> illegal=0, retired=0, FETCH.
- rst asserted in MEM_WR while mem_ready=0 -> mem_write=0 in the rst cycle; FETCH on the following cycle; retired=0.

Source files
------------

// File: rtl/samab_main_control.sv
// Multi-cycle main control FSM for the SAMAB CPU datapath: sequences
// fetch/decode/execute/memory/writeback and counts retired instructions.
module samab_main_control #(
  parameter int unsigned OPW  = 4,
  parameter int unsigned CNTW = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [OPW-1:0]  opcode,
  input  logic            zero,
  input  logic            mem_ready,
  output logic [2:0]      ops,
  output logic            ir_write,
  output logic            pc_write,
  output logic            pc_write_cond,
  output logic [1:0]      pc_src,
  output logic            iord,
  output logic            mem_read,
  output logic            mem_write,
  output logic            alu_src_a,
  output logic [1:0]      alu_src_b,
  output logic            reg_dst,
  output logic            mem_to_reg,
  output logic            reg_write,
  output logic            halted,
  output logic            illegal,
  output logic [CNTW-1:0] retired
);

  localparam logic [OPW-1:0] OP_RTYPE = OPW'(4'h0);
  localparam logic [OPW-1:0] OP_ADDI  = OPW'(4'h1);
  localparam logic [OPW-1:0] OP_LW    = OPW'(4'h2);
  localparam logic [OPW-1:0] OP_SW    = OPW'(4'h3);
  localparam logic [OPW-1:0] OP_BEQ   = OPW'(4'h4);
  localparam logic [OPW-1:0] OP_J     = OPW'(4'h5);
  localparam logic [OPW-1:0] OP_HALT  = OPW'(4'hF);

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b011;
  localparam logic [2:0] ALU_R   = 3'b100;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_EXEC_R, S_WB_R, S_ADDR, S_WB_I,
    S_MEM_RD, S_WB_MEM, S_MEM_WR, S_BRANCH, S_JUMP, S_HALT
  } state_e;

  state_e          state_q, state_d;
  logic [CNTW-1:0] retired_q, retired_d;
  logic            illegal_q, illegal_d;
  logic            retire;

  // The zero flag qualifies pc_write_cond in the datapath, not here.
  logic unused_zero;
  assign unused_zero = zero;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_FETCH;
      retired_q <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      retired_q <= retired_d;
      illegal_q <= illegal_d;
    end
  end

  // Next-state and Moore output decode; reset forces every control low.
  always_comb begin
    state_d       = state_q;
    illegal_d     = illegal_q;
    retire        = 1'b0;
    ops           = ALU_ADD;
    ir_write      = 1'b0;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    pc_src        = 2'b00;
    iord          = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'b00;
    reg_dst       = 1'b0;
    mem_to_reg    = 1'b0;
    reg_write     = 1'b0;
    halted        = 1'b0;

    unique case (state_q)
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        if (mem_ready) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          state_d  = S_DECODE;
        end
      end
      S_DECODE: begin
        alu_src_b = 2'b10;
        case (opcode)
          OP_RTYPE:              state_d = S_EXEC_R;
          OP_ADDI, OP_LW, OP_SW: state_d = S_ADDR;
          OP_BEQ:                state_d = S_BRANCH;
          OP_J:                  state_d = S_JUMP;
          OP_HALT:               state_d = S_HALT;
          default: begin
            state_d   = S_HALT;
            illegal_d = 1'b1;
          end
        endcase
      end
      S_EXEC_R: begin
        alu_src_a = 1'b1;
        ops       = ALU_R;
        state_d   = S_WB_R;
      end
      S_WB_R: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
        retire    = 1'b1;
        state_d   = S_FETCH;
      end
      S_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        case (opcode)
          OP_LW:   state_d = S_MEM_RD;
          OP_SW:   state_d = S_MEM_WR;
          default: state_d = S_WB_I;
        endcase
      end
      S_WB_I: begin
        reg_write = 1'b1;
        retire    = 1'b1;
        state_d   = S_FETCH;
      end
      S_MEM_RD: begin
        mem_read = 1'b1;
        iord     = 1'b1;
        if (mem_ready) state_d = S_WB_MEM;
      end
      S_WB_MEM: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        retire     = 1'b1;
        state_d    = S_FETCH;
      end
      S_MEM_WR: begin
        mem_write = 1'b1;
        iord      = 1'b1;
        if (mem_ready) begin
          retire  = 1'b1;
          state_d = S_FETCH;
        end
      end
      S_BRANCH: begin
        alu_src_a     = 1'b1;
        ops           = ALU_SUB;
        pc_write_cond = 1'b1;
        pc_src        = 2'b01;
        retire        = 1'b1;
        state_d       = S_FETCH;
      end
      S_JUMP: begin
        pc_write = 1'b1;
        pc_src   = 2'b10;
        retire   = 1'b1;
        state_d  = S_FETCH;
      end
      S_HALT: begin
        halted = 1'b1;
      end
      default: state_d = S_FETCH;
    endcase

    retired_d = retire ? retired_q + CNTW'(1) : retired_q;

    if (rst) begin
      ops           = ALU_ADD;
      ir_write      = 1'b0;
      pc_write      = 1'b0;
      pc_write_cond = 1'b0;
      pc_src        = 2'b00;
      iord          = 1'b0;
      mem_read      = 1'b0;
      mem_write     = 1'b0;
      alu_src_a     = 1'b0;
      alu_src_b     = 2'b00;
      reg_dst       = 1'b0;
      mem_to_reg    = 1'b0;
      reg_write     = 1'b0;
      halted        = 1'b0;
    end
  end

  assign illegal = illegal_q;
  assign retired = retired_q;

endmodule
